mdio_master_c45: RTL and testbench

- Parametrised MDIO management-frame master; successor to the Clause-22-only write/read engine.
- Adds Clause 45 frames, configurable preamble length, a post-frame idle gap, a read-acknowledge check and command rejection.
- Clocked directly by MDC and drives the bidirectional MDIO pin through a board/testbench pull-up.
- Sits between the PHY-configuration sequencer and the Ethernet PHY.

---
 rtl/mdio_master_c45.sv | 165 ++++++++++++++++
 tb/tb_mdio_master_c45.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master_c45.sv
// MDIO management-frame master for Clause 22 and Clause 45 frames, clocked directly by MDC.
// MDIO is only ever driven or released; the released level comes from an external pull-up.
module mdio_master_c45 #(
   parameter int PRE_LEN     = 32,
   parameter bit ENABLE_C45  = 1'b1,
   parameter int IDLE_CYCLES = 2
) (
   input  logic        mdc,
   input  logic        rst_n,
   input  logic        start,
   input  logic        c45,
   input  logic [1:0]  op,
   input  logic [4:0]  phy_addr,
   input  logic [4:0]  reg_addr,
   input  logic [15:0] wr_data,
   inout  wire         mdio,
   output logic        busy,
   output logic        done,
   output logic [15:0] rd_data,
   output logic        ack_err
);
   localparam int FRAME_LEN = PRE_LEN + 32;
   localparam int GAP_W     = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam logic [5:0] LAST_BIT  = 6'(FRAME_LEN - 1);
   localparam logic [5:0] TA2_BIT   = 6'(PRE_LEN + 15);
   localparam logic [5:0] DATA0_BIT = 6'(PRE_LEN + 16);
   localparam logic [6:0] PRE_LEN7  = 7'(PRE_LEN);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_ST, S_OP, S_PA, S_RA, S_TA, S_DATA, S_GAP, S_REJ
   } state_t;

   state_t           state;
   logic [5:0]       cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             c45_q, rd_q, ack_q, mdio_oe, mdio_o;
   logic [1:0]       op_q;
   logic [4:0]       pa_q, ra_q;
   logic [15:0]      wd_q, shreg;

   logic             can_accept, accept, in_frame, mdio_in;
   logic             n_c45, n_rd, n_rej, n_oe, n_bit;
   logic [1:0]       n_op;
   logic [4:0]       n_pa, n_ra;
   logic [15:0]      n_wd;
   logic [5:0]       nidx;
   logic [6:0]       pos;
   logic [31:0]      frm;
   state_t           n_fld;

   assign mdio    = mdio_oe ? mdio_o : 1'bz;
   assign mdio_in = mdio;

   // The bit for the next cycle comes from the inputs on the accept edge, else from the latched command.
   always_comb begin
      can_accept = (state == S_IDLE) || (state == S_REJ) || ((state == S_GAP) && (gap_cnt == '0));
      accept     = can_accept && start;
      in_frame   = (state != S_IDLE) && (state != S_REJ) && (state != S_GAP);
      n_c45      = can_accept ? (c45 && ENABLE_C45) : c45_q;
      n_op       = can_accept ? op       : op_q;
      n_pa       = can_accept ? phy_addr : pa_q;
      n_ra       = can_accept ? reg_addr : ra_q;
      n_wd       = can_accept ? wr_data  : wd_q;
      n_rd       = n_c45 ? n_op[1] : (n_op == 2'b10);
      n_rej      = !n_c45 && ((n_op == 2'b00) || (n_op == 2'b11));
      nidx       = can_accept ? 6'd0 : cnt + 6'd1;
      pos        = {1'b0, nidx} - PRE_LEN7;
      frm        = {1'b0, !n_c45, n_op, n_pa, n_ra, 2'b10, n_wd};
      n_fld      = S_DATA;
      n_oe       = 1'b1;
      n_bit      = 1'b1;
      if (pos[6]) begin
         n_fld = S_PRE;
      end else begin
         n_bit = frm[5'd31 - pos[4:0]];
         if (n_rd && (pos[5:0] >= 6'd14)) n_oe = 1'b0;
         if (pos[5:0] < 6'd2)       n_fld = S_ST;
         else if (pos[5:0] < 6'd4)  n_fld = S_OP;
         else if (pos[5:0] < 6'd9)  n_fld = S_PA;
         else if (pos[5:0] < 6'd14) n_fld = S_RA;
         else if (pos[5:0] < 6'd16) n_fld = S_TA;
      end
   end

   always_ff @(posedge mdc or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         gap_cnt <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ack_err <= 1'b0;
         rd_data <= '0;
         mdio_oe <= 1'b0;
         mdio_o  <= 1'b0;
         c45_q   <= 1'b0;
         op_q    <= 2'b00;
         rd_q    <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         done    <= 1'b0;
         ack_err <= 1'b0;
         case (state)
            S_IDLE: begin
            end
            S_REJ: begin
               done    <= 1'b1;
               ack_err <= 1'b1;
               busy    <= 1'b0;
               state   <= S_IDLE;
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               if (cnt == LAST_BIT) begin
                  state   <= S_GAP;
                  gap_cnt <= GAP_W'(IDLE_CYCLES - 1);
                  mdio_oe <= 1'b0;
                  done    <= 1'b1;
                  ack_err <= rd_q && ack_q;
                  if (rd_q) rd_data <= {shreg[14:0], mdio_in};
               end else begin
                  state   <= n_fld;
                  cnt     <= nidx;
                  mdio_oe <= n_oe;
                  mdio_o  <= n_bit;
                  // A PHY that answers pulls the second turnaround bit low.
                  if (rd_q && (cnt == TA2_BIT)) ack_q <= mdio_in;
               end
            end
         endcase
         if (accept) begin
            busy  <= 1'b1;
            c45_q <= n_c45;
            op_q  <= n_op;
            rd_q  <= n_rd;
            ack_q <= 1'b0;
            if (n_rej) begin
               state <= S_REJ;
            end else begin
               state   <= n_fld;
               cnt     <= '0;
               mdio_oe <= n_oe;
               mdio_o  <= n_bit;
            end
         end
      end
   end

   always_ff @(posedge mdc) begin
      if (accept) begin
         pa_q <= n_pa;
         ra_q <= n_ra;
         wd_q <= n_wd;
      end
      if (in_frame && rd_q && (cnt >= DATA0_BIT)) shreg <= {shreg[14:0], mdio_in};
   end

endmodule

// File: tb/tb_mdio_master_c45.sv
// Scoreboard bench for mdio_master_c45: a 32-bit-preamble instance with a PHY model on its MDIO,
// and a preamble-suppressed, Clause-22-only instance with a bare pull-up.
module tb_mdio_master_c45;
   logic        mdc = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, c45 = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [4:0]  phy_addr = '0, reg_addr = '0;
   logic [15:0] wr_data = '0;
   logic        busy, done, ack_err;
   logic [15:0] rd_data;
   logic        start_b = 1'b0, c45_b = 1'b0;
   logic [1:0]  op_b = 2'b00;
   logic [4:0]  phy_addr_b = '0, reg_addr_b = '0;
   logic [15:0] wr_data_b = '0;
   logic        busy_b, done_b, ack_err_b;
   logic [15:0] rd_data_b;
   wire         mdio, mdio_b;
   logic        phy_en = 1'b0, phy_val = 1'b0;

   assign mdio = phy_en ? phy_val : 1'bz;
   pullup (mdio);
   pullup (mdio_b);

   mdio_master_c45 #(.PRE_LEN(32), .ENABLE_C45(1'b1), .IDLE_CYCLES(2)) dut (
      .mdc(mdc), .rst_n(rst_n), .start(start), .c45(c45), .op(op), .phy_addr(phy_addr),
      .reg_addr(reg_addr), .wr_data(wr_data), .mdio(mdio), .busy(busy), .done(done),
      .rd_data(rd_data), .ack_err(ack_err));

   mdio_master_c45 #(.PRE_LEN(0), .ENABLE_C45(1'b0), .IDLE_CYCLES(2)) dut_b (
      .mdc(mdc), .rst_n(rst_n), .start(start_b), .c45(c45_b), .op(op_b), .phy_addr(phy_addr_b),
      .reg_addr(reg_addr_b), .wr_data(wr_data_b), .mdio(mdio_b), .busy(busy_b), .done(done_b),
      .rd_data(rd_data_b), .ack_err(ack_err_b));

   always #5 mdc = ~mdc;

   typedef struct { int cyc; int sig; int val; } pin_t;
   typedef struct { int cyc; int rd; int ack; } cmp_t;
   pin_t        pin_q[$];
   cmp_t        cq_a[$], cq_b[$];
   cmp_t        ea, eb;
   int          nchk = 0, nerr = 0;
   int          cyc = 0;
   int          bfm_n = -1000, bk;
   logic [16:0] bfm_word = '0, btmp;
   int          n, n2;

   always @(posedge mdc) cyc <= cyc + 1;

   function automatic void chk(string nm, int act, int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic string sig_name(int s);
      case (s)
         0: return "mdio_a";
         1: return "busy_a";
         2: return "mdio_b";
         default: return "busy_b";
      endcase
   endfunction

   function automatic int sample(int s);
      case (s)
         0: return int'(mdio);
         1: return int'(busy);
         2: return int'(mdio_b);
         default: return int'(busy_b);
      endcase
   endfunction

   function automatic void exp_pin(int c, int s, int v);
      pin_t e;
      e.cyc = c; e.sig = s; e.val = v;
      pin_q.push_back(e);
   endfunction

   // Wire-level bits: preamble ones, then the hand-built 32-bit word (released bits show the pull-up or PHY).
   function automatic void exp_frame(int s, int start_cyc, int pre, logic [31:0] word, int nbits);
      logic [31:0] w;
      for (int k = 0; k < nbits; k++) begin
         if (k < pre) begin
            exp_pin(start_cyc + k, s, 1);
         end else begin
            w = word << (k - pre);
            exp_pin(start_cyc + k, s, int'(w[31]));
         end
      end
   endfunction

   function automatic void exp_done(bit which, int c, int rd, int ack);
      cmp_t e;
      e.cyc = c; e.rd = rd; e.ack = ack;
      if (which) cq_b.push_back(e);
      else cq_a.push_back(e);
   endfunction

   task automatic set_a(input logic c, input logic [1:0] o, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd);
      start = 1'b1; c45 = c; op = o; phy_addr = pa; reg_addr = ra; wr_data = wd;
   endtask

   task automatic set_b(input logic c, input logic [1:0] o, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd);
      start_b = 1'b1; c45_b = c; op_b = o; phy_addr_b = pa; reg_addr_b = ra; wr_data_b = wd;
   endtask

   // PHY model: drives TA bit 2 and the 16 data bits of a read that started at edge bfm_n.
   always @(posedge mdc) begin
      #1;
      bk = cyc - bfm_n;
      if (bk >= 47 && bk <= 63) begin
         btmp    = bfm_word >> (63 - bk);
         phy_val = btmp[0];
         phy_en  = 1'b1;
      end else begin
         phy_en = 1'b0;
      end
   end

   always @(negedge mdc) begin
      for (int i = pin_q.size() - 1; i >= 0; i--) begin
         if (pin_q[i].cyc == cyc) begin
            chk(sig_name(pin_q[i].sig), sample(pin_q[i].sig), pin_q[i].val);
            pin_q.delete(i);
         end
      end
      if (done) begin
         if (cq_a.size() == 0) chk("done_a_unexpected", int'(done), 0);
         else begin
            ea = cq_a.pop_front();
            chk("done_a_cycle", cyc, ea.cyc);
            chk("rd_data_a", int'(rd_data), ea.rd);
            chk("ack_err_a", int'(ack_err), ea.ack);
         end
      end
      if (done_b) begin
         if (cq_b.size() == 0) chk("done_b_unexpected", int'(done_b), 0);
         else begin
            eb = cq_b.pop_front();
            chk("done_b_cycle", cyc, eb.cyc);
            chk("rd_data_b", int'(rd_data_b), eb.rd);
            chk("ack_err_b", int'(ack_err_b), eb.ack);
         end
      end
   end

   initial begin
      repeat (3) @(negedge mdc);
      chk("rst_busy_a", int'(busy), 0);
      chk("rst_done_a", int'(done), 0);
      chk("rst_rd_data_a", int'(rd_data), 0);
      chk("rst_ack_err_a", int'(ack_err), 0);
      chk("rst_mdio_a", int'(mdio), 1);
      chk("rst_busy_b", int'(busy_b), 0);
      chk("rst_done_b", int'(done_b), 0);
      chk("rst_mdio_b", int'(mdio_b), 1);
      rst_n = 1'b1;
      repeat (2) @(negedge mdc);

      // C22 write phy=0 reg=0 data=0x2100
      n = cyc + 1;
      exp_frame(0, n, 32, 32'h5002_2100, 64);
      exp_done(1'b0, n + 64, 'h0000, 0);
      exp_pin(n, 1, 1); exp_pin(n + 64, 0, 1); exp_pin(n + 65, 1, 1); exp_pin(n + 66, 1, 0);
      set_a(1'b0, 2'b01, 5'd0, 5'd0, 16'h2100);
      @(negedge mdc); start = 1'b0;
      repeat (70) @(negedge mdc);

      // C22 read phy=1 reg=2, PHY answers 0x796D
      n = cyc + 1;
      bfm_n = n; bfm_word = {1'b0, 16'h796D};
      exp_frame(0, n, 32, 32'h608A_796D, 64);
      exp_done(1'b0, n + 64, 'h796D, 0);
      set_a(1'b0, 2'b10, 5'd1, 5'd2, 16'h0000);
      @(negedge mdc); start = 1'b0;
      repeat (70) @(negedge mdc);

      // C22 read with no PHY present
      n = cyc + 1;
      exp_frame(0, n, 32, 32'h6003_FFFF, 64);
      exp_done(1'b0, n + 64, 'hFFFF, 1);
      set_a(1'b0, 2'b10, 5'd0, 5'd0, 16'h0000);
      @(negedge mdc); start = 1'b0;
      repeat (70) @(negedge mdc);

      // C45 address then C45 read held on start through the first command
      n = cyc + 1;
      exp_frame(0, n, 32, 32'h0186_0010, 64);
      exp_done(1'b0, n + 64, 'hFFFF, 0);
      exp_pin(n + 64, 0, 1); exp_pin(n + 65, 0, 1); exp_pin(n + 65, 1, 1);
      set_a(1'b1, 2'b00, 5'd3, 5'd1, 16'h0010);
      @(negedge mdc); start = 1'b0;
      repeat (9) @(negedge mdc);
      n2 = n + 66;
      bfm_n = n2; bfm_word = {1'b0, 16'h1234};
      exp_frame(0, n2, 32, 32'h3186_1234, 64);
      exp_done(1'b0, n2 + 64, 'h1234, 0);
      exp_pin(n2, 1, 1); exp_pin(n2 + 66, 1, 0);
      set_a(1'b1, 2'b11, 5'd3, 5'd1, 16'h0000);
      while (cyc < n2) @(negedge mdc);
      start = 1'b0;
      repeat (70) @(negedge mdc);

      // Preamble-suppressed C22 write; start held while busy must not queue a second frame
      n = cyc + 1;
      exp_frame(2, n, 0, 32'h5FAA_A5C3, 32);
      exp_done(1'b1, n + 32, 'h0000, 0);
      exp_pin(n + 32, 2, 1); exp_pin(n + 33, 3, 1); exp_pin(n + 34, 3, 0); exp_pin(n + 36, 3, 0);
      set_b(1'b0, 2'b01, 5'h1F, 5'h0A, 16'hA5C3);
      repeat (10) @(negedge mdc);
      start_b = 1'b0;
      repeat (40) @(negedge mdc);

      // c45=1 on the Clause-22-only instance: op=11 is rejected
      n = cyc + 1;
      exp_done(1'b1, n + 1, 'h0000, 1);
      exp_pin(n, 3, 1); exp_pin(n + 1, 3, 0);
      for (int k = 0; k < 4; k++) exp_pin(n + k, 2, 1);
      set_b(1'b1, 2'b11, 5'h01, 5'h01, 16'hFFFF);
      @(negedge mdc); start_b = 1'b0;
      repeat (6) @(negedge mdc);

      // C22 op=11 rejected; rd_data keeps the last read value
      n = cyc + 1;
      exp_done(1'b0, n + 1, 'h1234, 1);
      exp_pin(n, 1, 1); exp_pin(n + 1, 1, 0);
      for (int k = 0; k < 4; k++) exp_pin(n + k, 0, 1);
      set_a(1'b0, 2'b11, 5'd0, 5'd0, 16'h0000);
      @(negedge mdc); start = 1'b0;
      repeat (6) @(negedge mdc);

      // Reset in the middle of the data field of a write
      n = cyc + 1;
      exp_frame(0, n, 32, 32'h5002_0000, 52);
      set_a(1'b0, 2'b01, 5'd0, 5'd0, 16'h0000);
      @(negedge mdc); start = 1'b0;
      while (cyc < n + 52) @(negedge mdc);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mdio", int'(mdio), 1);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_rd_data", int'(rd_data), 0);
      repeat (3) @(negedge mdc);
      rst_n = 1'b1;
      repeat (2) @(negedge mdc);

      // Write after reset completes normally
      n = cyc + 1;
      exp_frame(0, n, 32, 32'h5112_8001, 64);
      exp_done(1'b0, n + 64, 'h0000, 0);
      exp_pin(n + 66, 1, 0);
      set_a(1'b0, 2'b01, 5'd2, 5'd4, 16'h8001);
      @(negedge mdc); start = 1'b0;
      repeat (72) @(negedge mdc);

      foreach (pin_q[i]) begin
         nchk++; nerr++;
         $display("FAIL %s_missed: cycle %0d never checked, expected %0d", sig_name(pin_q[i].sig),
                  pin_q[i].cyc, pin_q[i].val);
      end
      foreach (cq_a[i]) begin
         nchk++; nerr++;
         $display("FAIL done_a_missing: no done, expected at cycle %0d", cq_a[i].cyc);
      end
      foreach (cq_b[i]) begin
         nchk++; nerr++;
         $display("FAIL done_b_missing: no done, expected at cycle %0d", cq_b[i].cyc);
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
